bmp_upload_reader: RTL

//  Serves a data_io upload (ioctl_upload) by streaming the SRAM framebuffer back to the host as a 32bpp BMP.

---
 rtl/bmp_upload_pkg.sv | 30 +++
 rtl/bmp_header_rom.sv | 40 ++++
 rtl/bmp_upload_reader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bmp_upload_pkg.sv
// Shared constants, state/region enums and byte-select helpers for the BMP upload reader.
package bmp_upload_pkg;
  localparam int HDR_LEN      = 54;
  localparam int BMP_DIB_SIZE = 40;
  localparam int BMP_BPP      = 32;
  localparam int BMP_PPM      = 2835;

  typedef enum logic [1:0] {IDLE, SERVE, FETCH} state_t;
  typedef enum logic [1:0] {HDR, PIX, TRAIL, PAST} region_t;

  // Little-endian byte i of a 32-bit field (i=0 -> [7:0]).
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] i);
    case (i)
      2'd0:    le_byte = v[7:0];
      2'd1:    le_byte = v[15:8];
      2'd2:    le_byte = v[23:16];
      default: le_byte = v[31:24];
    endcase
  endfunction

  // SRAM word lane select: lane 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] v, input logic [1:0] i);
    case (i)
      2'd0:    be_byte = v[31:24];
      2'd1:    be_byte = v[23:16];
      2'd2:    be_byte = v[15:8];
      default: be_byte = v[7:0];
    endcase
  endfunction
endpackage

// File: rtl/bmp_header_rom.sv
// 54-byte BMP file + DIB header for a 32bpp bottom-up image, as a combinational byte mux.
// Every field after 'BM' is 4-byte aligned from offset 2 (planes/bpp packed as one word).
module bmp_header_rom
  import bmp_upload_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 256
) (
  input  logic [5:0] i_addr,
  output logic [7:0] o_byte
);
  localparam logic [31:0] IMG_SZ  = 32'(IMG_W * IMG_H * 4);
  localparam logic [31:0] FILE_SZ = IMG_SZ + 32'(HDR_LEN);

  logic [5:0]  w_rel;
  logic [31:0] w_fld;

  assign w_rel = i_addr - 6'd2;

  // Pick the 32-bit field covering this offset, then the byte inside it.
  always_comb begin
    w_fld = '0;
    case (w_rel[5:2])
      4'd0:    w_fld = FILE_SZ;
      4'd2:    w_fld = 32'(HDR_LEN);
      4'd3:    w_fld = 32'(BMP_DIB_SIZE);
      4'd4:    w_fld = 32'(IMG_W);
      4'd5:    w_fld = 32'(IMG_H);
      4'd6:    w_fld = {16'(BMP_BPP), 16'd1};
      4'd8:    w_fld = IMG_SZ;
      4'd9:    w_fld = 32'(BMP_PPM);
      4'd10:   w_fld = 32'(BMP_PPM);
      default: w_fld = '0;
    endcase
    if (i_addr == 6'd0)       o_byte = 8'h42;
    else if (i_addr == 6'd1)  o_byte = 8'h4D;
    else if (i_addr >= 6'(HDR_LEN)) o_byte = 8'h00;
    else                      o_byte = le_byte(w_fld, w_rel[1:0]);
  end
endmodule

// File: rtl/bmp_upload_reader.sv
// Streams the SRAM framebuffer to data_io as a 32bpp BMP on upload.
// One-word read buffer in front of the SRAM arbiter; header synthesized by bmp_header_rom.
// Optional macro BMP_UPLOAD_CHECKSUM_EN appends a 4-byte LE sum of consumed pixel bytes.
module bmp_upload_reader
  import bmp_upload_pkg::*;
#(
  parameter int          IMG_W        = 512,
  parameter int          IMG_H        = 256,
  parameter int          ADDR_W       = 19,
  parameter logic [7:0]  UPLOAD_INDEX = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_wr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_din_valid,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_q,
  output logic              busy
);
  localparam logic [24:0] PIX_END   = 25'(HDR_LEN + IMG_W * IMG_H * 4);
  localparam logic [24:0] TRAIL_END = PIX_END + 25'd4;

  state_t            r_state;
  logic              r_upload_d;
  logic [7:0]        r_din;
  logic              r_din_valid;
  logic [24:0]       r_din_addr;
  logic              r_mem_req;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_buf;
  logic [ADDR_W-3:0] r_tag;
  logic              r_buf_vld;

  region_t           w_region;
  logic [24:0]       w_off;
  logic [ADDR_W-3:0] w_word;
  logic [1:0]        w_lane;
  logic              w_hit;
  logic [7:0]        w_hdr_byte;
  logic              w_unused;

`ifdef BMP_UPLOAD_CHECKSUM_EN
  logic [31:0]       r_sum;
  logic              r_wr_d;
  logic              r_din_pix;
  logic [24:0]       w_trail;
  logic              w_wr_rise;
  assign w_trail   = ioctl_addr - PIX_END;
  assign w_wr_rise = ioctl_wr & ~r_wr_d;
  assign w_unused  = &{1'b0, w_off[24:ADDR_W], w_trail[24:2]};
`else
  assign w_unused  = &{1'b0, w_off[24:ADDR_W], ioctl_wr};
`endif

  assign w_off  = ioctl_addr - 25'(HDR_LEN);
  assign w_word = w_off[ADDR_W-1:2];
  assign w_lane = w_off[1:0];
  assign w_hit  = r_buf_vld && (r_tag == w_word);

  // Classify the requested offset; anything at or above 2**24 is past the image.
  always_comb begin
    if (ioctl_addr[24])                      w_region = PAST;
    else if (ioctl_addr < 25'(HDR_LEN))      w_region = HDR;
    else if (ioctl_addr < PIX_END)           w_region = PIX;
`ifdef BMP_UPLOAD_CHECKSUM_EN
    else if (ioctl_addr < TRAIL_END)         w_region = TRAIL;
`endif
    else                                     w_region = PAST;
  end

  bmp_header_rom #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_hdr (
    .i_addr (ioctl_addr[5:0]),
    .o_byte (w_hdr_byte)
  );

  // Upload FSM: decode/serve, single-word fetch, and consumed-byte sum.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_upload_d  <= 1'b0;
      r_din       <= '0;
      r_din_valid <= 1'b0;
      r_din_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_buf       <= '0;
      r_tag       <= '0;
      r_buf_vld   <= 1'b0;
`ifdef BMP_UPLOAD_CHECKSUM_EN
      r_sum       <= '0;
      r_wr_d      <= 1'b0;
      r_din_pix   <= 1'b0;
`endif
    end else begin
      r_upload_d <= ioctl_upload;
`ifdef BMP_UPLOAD_CHECKSUM_EN
      r_wr_d     <= ioctl_wr;
`endif
      if (!ioctl_upload) begin
        r_state     <= IDLE;
        r_mem_req   <= 1'b0;
        r_din_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_din_valid <= 1'b0;
            if (!r_upload_d && ioctl_index == UPLOAD_INDEX) begin
              r_state   <= SERVE;
              r_buf_vld <= 1'b0;
`ifdef BMP_UPLOAD_CHECKSUM_EN
              r_sum     <= '0;
`endif
            end
          end
          SERVE: begin
`ifdef BMP_UPLOAD_CHECKSUM_EN
            // The byte on ioctl_din is the one being consumed on this strobe.
            if (w_wr_rise && ioctl_din_valid && r_din_pix)
              r_sum <= r_sum + {24'd0, r_din};
            r_din_pix <= 1'b0;
`endif
            r_din_addr  <= ioctl_addr;
            r_din_valid <= 1'b1;
            case (w_region)
              HDR: r_din <= w_hdr_byte;
              PIX: begin
                if (w_hit) begin
                  r_din <= be_byte(r_buf, w_lane);
`ifdef BMP_UPLOAD_CHECKSUM_EN
                  r_din_pix <= 1'b1;
`endif
                end else begin
                  r_din_valid <= 1'b0;
                  r_mem_req   <= 1'b1;
                  r_mem_addr  <= w_word;
                  r_state     <= FETCH;
                end
              end
`ifdef BMP_UPLOAD_CHECKSUM_EN
              TRAIL: r_din <= le_byte(r_sum, w_trail[1:0]);
`endif
              default: r_din <= 8'h00;
            endcase
          end
          FETCH: begin
            r_din_valid <= 1'b0;
            if (mem_ack) begin
              r_buf     <= mem_q;
              r_tag     <= r_mem_addr;
              r_buf_vld <= 1'b1;
              r_mem_req <= 1'b0;
              r_state   <= SERVE;
              // Serve straight from the returning word if the host is still on it.
              if (w_region == PIX && w_word == r_mem_addr) begin
                r_din       <= be_byte(mem_q, w_lane);
                r_din_valid <= 1'b1;
                r_din_addr  <= ioctl_addr;
`ifdef BMP_UPLOAD_CHECKSUM_EN
                r_din_pix   <= 1'b1;
`endif
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ioctl_din       = r_din;
  assign ioctl_din_valid = r_din_valid && (r_din_addr == ioctl_addr);
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
  assign busy            = (r_state != IDLE);
endmodule
